// File: rtl/flag_pkg.sv
// Shared types for the status-flag controller: FSM state encoding and the
// carry/zero flag pair used for both the live and the shadow copies.
package flag_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    INTR = 1'b1
  } flag_state_t;

  typedef struct packed {
    logic c;
    logic z;
  } flags_t;

endpackage

// File: rtl/flag_reg.sv
// Single-bit flag register with synchronous reset and load enable.
module flag_reg #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ld_i,
  input  logic d_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= RST_VAL;
    end else if (ld_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/flag_ctrl.sv
// MCU status flags C/Z/I with a single-level shadow copy and the interrupt
// acceptance sequence (RUN -> one-cycle INTR acknowledge -> RUN).
module flag_ctrl
  import flag_pkg::*;
#(
  parameter logic RST_I     = 1'b0,
  parameter int   SHADOW_EN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic c_in,
  input  logic z_in,
  input  logic flg_ld,
  input  logic c_set,
  input  logic c_clr,
  input  logic i_set,
  input  logic i_clr,
  input  logic reti,
  input  logic inst_done,
  input  logic intr_req,
  output logic c_flag,
  output logic z_flag,
  output logic i_flag,
  output logic int_pending,
  output logic int_ack
);

  flag_state_t state_q;
  logic        pend_q;
  flags_t      flg_q, flg_d, flg_en;
  flags_t      shd_q;
  logic        i_q, i_d, i_en;
  logic        in_intr;
  logic        shd_en;

  assign in_intr = (state_q == INTR);
  assign shd_en  = in_intr && (SHADOW_EN != 0);

  // Next-value muxing; INTR clears everything and ignores all strobes.
  always_comb begin
    flg_d  = '0;
    flg_en = '0;
    i_d    = 1'b0;
    i_en   = 1'b0;
    if (in_intr) begin
      flg_en = '1;
      i_en   = 1'b1;
    end else begin
      if (reti) begin
        if (SHADOW_EN != 0) begin
          flg_en = '1;
          flg_d  = shd_q;
        end
      end else if (flg_ld) begin
        flg_en = '1;
        flg_d  = '{c: c_in, z: z_in};
      end else if (c_set) begin
        flg_en.c = 1'b1;
        flg_d.c  = 1'b1;
      end else if (c_clr) begin
        flg_en.c = 1'b1;
      end
      if (reti || i_set) begin
        i_en = 1'b1;
        i_d  = 1'b1;
      end else if (i_clr) begin
        i_en = 1'b1;
      end
    end
  end

  // Accept only on a boundary with a registered pending request and I=1;
  // a request arriving during INTR survives the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN:     state_q <= (inst_done && pend_q && i_q) ? INTR : RUN;
        INTR:    state_q <= RUN;
        default: state_q <= RUN;
      endcase
      if (intr_req) begin
        pend_q <= 1'b1;
      end else if (in_intr) begin
        pend_q <= 1'b0;
      end
    end
  end

  flag_reg #(.RST_VAL(1'b0)) u_c (
    .clk_i(clk), .rst_i(rst), .ld_i(flg_en.c), .d_i(flg_d.c), .q_o(flg_q.c)
  );
  flag_reg #(.RST_VAL(1'b0)) u_z (
    .clk_i(clk), .rst_i(rst), .ld_i(flg_en.z), .d_i(flg_d.z), .q_o(flg_q.z)
  );
  flag_reg #(.RST_VAL(RST_I)) u_i (
    .clk_i(clk), .rst_i(rst), .ld_i(i_en), .d_i(i_d), .q_o(i_q)
  );
  flag_reg #(.RST_VAL(1'b0)) u_shd_c (
    .clk_i(clk), .rst_i(rst), .ld_i(shd_en), .d_i(flg_q.c), .q_o(shd_q.c)
  );
  flag_reg #(.RST_VAL(1'b0)) u_shd_z (
    .clk_i(clk), .rst_i(rst), .ld_i(shd_en), .d_i(flg_q.z), .q_o(shd_q.z)
  );

  assign c_flag      = flg_q.c;
  assign z_flag      = flg_q.z;
  assign i_flag      = i_q;
  assign int_pending = pend_q;
  assign int_ack     = in_intr;

endmodule

// File: tb/tb_flag_ctrl.sv
// Directed bench for flag_ctrl: each stimulus cycle queues the hand-computed
// {c,z,i,pending,ack} expected after its clock edge; a monitor checks them.
module tb_flag_ctrl;

  logic clk = 1'b0;
  logic rst, c_in, z_in, flg_ld, c_set, c_clr, i_set, i_clr, reti;
  logic inst_done, intr_req;
  logic c_flag, z_flag, i_flag, int_pending, int_ack;

  logic [4:0] exp_q[$];
  string      name_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  flag_ctrl #(.RST_I(1'b0), .SHADOW_EN(1)) dut (
    .clk(clk), .rst(rst), .c_in(c_in), .z_in(z_in), .flg_ld(flg_ld),
    .c_set(c_set), .c_clr(c_clr), .i_set(i_set), .i_clr(i_clr),
    .reti(reti), .inst_done(inst_done), .intr_req(intr_req),
    .c_flag(c_flag), .z_flag(z_flag), .i_flag(i_flag),
    .int_pending(int_pending), .int_ack(int_ack)
  );

  task automatic idle_inputs();
    rst = 1'b0; c_in = 1'b0; z_in = 1'b0; flg_ld = 1'b0;
    c_set = 1'b0; c_clr = 1'b0; i_set = 1'b0; i_clr = 1'b0;
    reti = 1'b0; inst_done = 1'b0; intr_req = 1'b0;
  endtask

  // Apply the currently set inputs for one edge, queue the expected outputs,
  // then return inputs to idle for the next vector.
  task automatic tick(input logic [4:0] exp, input string name);
    @(posedge clk);
    #1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    idle_inputs();
  endtask

  // Monitor: outputs are sampled on the falling edge, away from updates.
  initial begin
    logic [4:0] act, exp;
    string      nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {c_flag, z_flag, i_flag, int_pending, int_ack};
        n_checks++;
        if (act !== exp) begin
          n_fail++;
          $display("FAIL %s: got czipa=%b expected %b", nm, act, exp);
        end
      end
    end
  end

  initial begin
    idle_inputs();
    #1;
    // Reset with every strobe high.
    for (int k = 0; k < 3; k++) begin
      rst = 1; c_in = 1; z_in = 1; flg_ld = 1; c_set = 1; c_clr = 1;
      i_set = 1; i_clr = 1; reti = 1; inst_done = 1; intr_req = 1;
      tick(5'b00000, "reset");
    end
    tick(5'b00000, "idle_after_reset");

    // Flag writes and priorities.
    c_in = 1; z_in = 0; flg_ld = 1;        tick(5'b10000, "alu_load");
    c_clr = 1;                             tick(5'b00000, "c_clr_z_hold");
    c_set = 1;                             tick(5'b10000, "c_set");
    c_set = 1; c_clr = 1;                  tick(5'b10000, "c_set_over_clr");
    flg_ld = 1; c_in = 0; z_in = 1; c_set = 1;
                                           tick(5'b01000, "ld_over_c_set");
    i_set = 1; i_clr = 1;                  tick(5'b01100, "i_set_over_clr");
    i_clr = 1;                             tick(5'b01000, "i_clr");
    flg_ld = 1;                            tick(5'b00000, "ld_zero");

    // Interrupt taken; the completing instruction's flags are saved.
    i_set = 1;                             tick(5'b00100, "sei");
    intr_req = 1;                          tick(5'b00110, "pend_set");
    inst_done = 1; flg_ld = 1; c_in = 1; z_in = 1;
                                           tick(5'b11111, "ack");
    c_set = 1; i_set = 1;                  tick(5'b00000, "intr_exit");

    // Masked request waits for I.
    intr_req = 1; inst_done = 1;           tick(5'b00010, "masked_pend");
    for (int k = 0; k < 10; k++) begin
      inst_done = 1;                       tick(5'b00010, "masked_hold");
    end
    i_set = 1; flg_ld = 1; c_in = 1; z_in = 1;
                                           tick(5'b11110, "unmask");
    inst_done = 1;                         tick(5'b11111, "ack_after_sei");
    reti = 1; i_set = 1;                   tick(5'b00000, "strobes_ignored");

    // RETI restores shadow 1/1 and wins over flg_ld.
    reti = 1; flg_ld = 1; c_in = 0; z_in = 0;
                                           tick(5'b11100, "reti_restore");

    // Request during INTR keeps pending set.
    intr_req = 1;                          tick(5'b11110, "pend_again");
    inst_done = 1;                         tick(5'b11111, "ack3");
    intr_req = 1;                          tick(5'b00010, "pend_kept");

    // Reset during INTR drops ack and the pending request.
    i_set = 1;                             tick(5'b00110, "sei2");
    inst_done = 1;                         tick(5'b00111, "ack4");
    rst = 1; intr_req = 1;                 tick(5'b00000, "rst_in_intr");
    inst_done = 1;                         tick(5'b00000, "after_rst");

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
